// File: rtl/sid_uart_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sid_uart_bridge_pkg
// Shared definitions for the SID UART bridge:
//   - RX FSM state encoding (IDLE, START, DATA, STOP)
//   - pair FSM state encoding (WAIT_ADDR, WAIT_DATA)
//   - derivation helpers for the bit period and the chip-select field width
// -----------------------------------------------------------------------------
package sid_uart_bridge_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        PAIR_WAIT_ADDR = 1'b0,
        PAIR_WAIT_DATA = 1'b1
    } pair_state_e;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int calc_bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Width of the channel field carried in the address byte; never below 1.
    function automatic int calc_ch_bits(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receiver: 2-FF input synchroniser, RX FSM and bit timer.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   rx_i         in   asynchronous serial input, idle high
//   byte_valid_o out  1-cycle strobe on the stop-bit sample of a good frame
//   rx_byte_o    out  received byte (valid with byte_valid_o)
//   frame_err_o  out  1-cycle strobe on the stop-bit sample of a bad frame
//   rx_busy_o    out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_core
    import sid_uart_bridge_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       frame_err_o,
    output logic       rx_busy_o
);

    localparam int BIT_CYC  = calc_bit_cyc(CLK_FREQ, BAUD);
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    if (BIT_CYC < 2) begin : g_bad_baud
        $error("uart_rx_core: CLK_FREQ/BAUD must be at least 2");
    end

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            prev_q, prev_d;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    logic expired;
    logic byte_valid;
    logic frame_err;

    // The timer expires when it reaches 0, so loading N-1 places the sample
    // exactly N cycles after the load.
    always_comb begin
        sync1_d    = rx_i;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        expired    = (cnt_q == '0);

        case (state_q)
            RX_IDLE: begin
                // Arming needs a high-to-low transition, so after a framing
                // error the line must return high before a new start counts.
                if (prev_q && !sync2_q) begin
                    cnt_d   = CNT_W'(HALF_CYC - 1);
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (expired) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d     = CNT_W'(BIT_CYC - 1);
                        bit_idx_d = 3'd0;
                        state_d   = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (expired) begin
                    shift_d   = {sync2_q, shift_q[7:1]};
                    cnt_d     = CNT_W'(BIT_CYC - 1);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (expired) begin
                    byte_valid = sync2_q;
                    frame_err  = !sync2_q;
                    state_d    = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Shift register is pure data; a stale value is never qualified.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign byte_valid_o = byte_valid;
    assign rx_byte_o    = shift_q;
    assign frame_err_o  = frame_err;
    assign rx_busy_o    = (state_q != RX_IDLE);

endmodule

// File: rtl/sid_uart_bridge.sv
// -----------------------------------------------------------------------------
// sid_uart_bridge
// Pairs received UART bytes as (address, data) and issues one register write
// per pair to one of CHANNELS SID chips over a valid/ready handshake.
// Ports:
//   CLK_IN       in   system clock
//   RST_N_i      in   synchronous active-low reset
//   RS232_RX_i   in   asynchronous serial input, idle high
//   WR_READY_i   in   SID bus accepts a write this cycle
//   WR_VALID_o   out  write pending
//   WR_ADDR_o    out  register address
//   WR_DATA_o    out  register data
//   WR_CS_o      out  one-hot chip select, valid with WR_VALID_o
//   FRAME_ERR_o  out  1-cycle pulse, bad stop bit
//   TIMEOUT_o    out  1-cycle pulse, pair abandoned after inter-byte timeout
//   OVERRUN_o    out  1-cycle pulse, completed pair dropped (write pending)
// -----------------------------------------------------------------------------
module sid_uart_bridge
    import sid_uart_bridge_pkg::*;
#(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int BAUD         = 115_200,
    parameter int ADDR_BITS    = 5,
    parameter int CHANNELS     = 2,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                 CLK_IN,
    input  logic                 RST_N_i,
    input  logic                 RS232_RX_i,
    input  logic                 WR_READY_i,
    output logic                 WR_VALID_o,
    output logic [ADDR_BITS-1:0] WR_ADDR_o,
    output logic [7:0]           WR_DATA_o,
    output logic [CHANNELS-1:0]  WR_CS_o,
    output logic                 FRAME_ERR_o,
    output logic                 TIMEOUT_o,
    output logic                 OVERRUN_o
);

    localparam int BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);
    localparam int CH_BITS = calc_ch_bits(CHANNELS);
    localparam int TO_CYC  = TIMEOUT_BITS * BIT_CYC;
    localparam int TO_W    = $clog2(TO_CYC + 1);

    if (ADDR_BITS + CH_BITS > 8) begin : g_bad_cfg
        $error("sid_uart_bridge: ADDR_BITS + CH_BITS must not exceed 8");
    end

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       rx_busy;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk          (CLK_IN),
        .rst_n        (RST_N_i),
        .rx_i         (RS232_RX_i),
        .byte_valid_o (byte_valid),
        .rx_byte_o    (rx_byte),
        .frame_err_o  (frame_err),
        .rx_busy_o    (rx_busy)
    );

    pair_state_e          pair_q, pair_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [ADDR_BITS-1:0] addr_lat_q, addr_lat_d;
    logic [CH_BITS-1:0]   ch_lat_q, ch_lat_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [CHANNELS-1:0]  wr_cs_q, wr_cs_d;
    logic                 frame_err_q, frame_err_d;
    logic                 timeout_q, timeout_d;
    logic                 overrun_q, overrun_d;

    logic                 pair_done;
    logic                 ch_ok;
    logic                 xfer;
    logic [CHANNELS-1:0]  cs_dec;

    always_comb begin
        pair_d      = pair_q;
        to_cnt_d    = to_cnt_q;
        addr_lat_d  = addr_lat_q;
        ch_lat_d    = ch_lat_q;
        wr_valid_d  = wr_valid_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_cs_d     = wr_cs_q;
        frame_err_d = frame_err;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;
        pair_done   = 1'b0;

        ch_ok = (32'(ch_lat_q) < CHANNELS);
        xfer  = wr_valid_q && WR_READY_i;
        for (int i = 0; i < CHANNELS; i++) begin
            cs_dec[i] = (32'(ch_lat_q) == i);
        end

        case (pair_q)
            PAIR_WAIT_ADDR: begin
                if (byte_valid) begin
                    addr_lat_d = rx_byte[ADDR_BITS-1:0];
                    ch_lat_d   = rx_byte[ADDR_BITS+CH_BITS-1:ADDR_BITS];
                    to_cnt_d   = TO_W'(TO_CYC - 1);
                    pair_d     = PAIR_WAIT_DATA;
                end
            end
            PAIR_WAIT_DATA: begin
                if (byte_valid) begin
                    pair_done = 1'b1;
                    pair_d    = PAIR_WAIT_ADDR;
                end else if (frame_err) begin
                    // Drop the address so the next good byte starts a new pair.
                    pair_d = PAIR_WAIT_ADDR;
                end else if (!rx_busy) begin
                    // Timer only runs while the line is idle; a frame in
                    // progress holds it.
                    if (to_cnt_q == '0) begin
                        timeout_d = 1'b1;
                        pair_d    = PAIR_WAIT_ADDR;
                    end else begin
                        to_cnt_d = to_cnt_q - TO_W'(1);
                    end
                end
            end
        endcase

        if (xfer) begin
            wr_valid_d = 1'b0;
        end

        // Pairs addressed to a non-existent chip vanish without a pulse.
        if (pair_done && ch_ok) begin
            if (!wr_valid_q || xfer) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_lat_q;
                wr_data_d  = rx_byte;
                wr_cs_d    = cs_dec;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N_i) begin
            pair_q      <= PAIR_WAIT_ADDR;
            to_cnt_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_cs_q     <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pair_q      <= pair_d;
            to_cnt_q    <= to_cnt_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_cs_q     <= wr_cs_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    // Latched address/channel are only read in WAIT_DATA, after being loaded.
    always_ff @(posedge CLK_IN) begin
        addr_lat_q <= addr_lat_d;
        ch_lat_q   <= ch_lat_d;
    end

    assign WR_VALID_o  = wr_valid_q;
    assign WR_ADDR_o   = wr_addr_q;
    assign WR_DATA_o   = wr_data_q;
    assign WR_CS_o     = wr_cs_q;
    assign FRAME_ERR_o = frame_err_q;
    assign TIMEOUT_o   = timeout_q;
    assign OVERRUN_o   = overrun_q;

endmodule
